// File: rtl/rtlrrpkt.sv
// Round-robin packet arbiter with per-packet grant lock.
// Feeds a one-hot bus selector and a single valid/ready output stage.
module rtlrrpkt #(
  parameter int N    = 6,
  parameter int O    = 8,
  parameter int I    = N * O,
  parameter int W    = 3,
  parameter int MAXB = 16,
  parameter int CW   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] eop,
  input  logic [I-1:0] in,
  output logic [N-1:0] gnt,
  output logic         ovld,
  input  logic         ordy,
  output logic [O-1:0] odat,
  output logic [W-1:0] oid,
  output logic         oeop,
  output logic         err
);

  typedef enum logic {
    IDLE,
    LOCK
  } st_t;

  st_t st, st_n;

  logic [W-1:0]  ptr, ptr_n;
  logic [W-1:0]  lid, lid_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  w, gid;
  logic          ld, hit, found;
  logic          last, trunc;
  int            k;

  function automatic logic [W-1:0] inc(input logic [W-1:0] x);
    return (x == W'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping.
  always_comb begin
    w     = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        w     = W'(k);
      end
    end
  end

  always_comb begin
    ld    = ~ovld | ordy;
    st_n  = st;
    ptr_n = ptr;
    lid_n = lid;
    cnt_n = cnt;
    gnt   = '0;
    hit   = 1'b0;
    gid   = w;
    last  = 1'b0;
    trunc = 1'b0;
    if (!rst && ld) begin
      unique case (st)
        IDLE: begin
          if (found) begin
            hit   = 1'b1;
            gid   = w;
            trunc = (MAXB == 1) & ~eop[w];
            last  = eop[w] | trunc;
            if (last) begin
              ptr_n = inc(w);
            end else begin
              st_n  = LOCK;
              lid_n = w;
              cnt_n = CW'(1);
            end
          end
        end
        LOCK: begin
          if (req[lid]) begin
            hit   = 1'b1;
            gid   = lid;
            cnt_n = cnt + 1'b1;
            trunc = ~eop[lid] & (cnt == CW'(MAXB - 1));
            last  = eop[lid] | trunc;
            if (last) begin
              st_n  = IDLE;
              ptr_n = inc(lid);
            end
          end
        end
        default: ;
      endcase
    end
    if (hit) gnt[gid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      lid  <= '0;
      cnt  <= '0;
      ovld <= 1'b0;
      odat <= '0;
      oid  <= '0;
      oeop <= 1'b0;
      err  <= 1'b0;
    end else begin
      ptr <= ptr_n;
      lid <= lid_n;
      cnt <= cnt_n;
      if (ld) begin
        if (hit) begin
          ovld <= 1'b1;
          odat <= in[int'(gid)*O +: O];
          oid  <= gid;
          oeop <= last;
          err  <= trunc;
        end else begin
          ovld <= 1'b0;
          err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtlrrpkt.sv
// Bench for rtlrrpkt: directed table, hand sequences,
// and random traffic against a packet-level reference model.
module tb_rtlrrpkt;
  localparam int N    = 6;
  localparam int O    = 8;
  localparam int W    = 3;
  localparam int MAXB = 16;
  localparam int CW   = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, eop, gnt;
  logic [N*O-1:0] in;
  logic           ordy, ovld, oeop, err;
  logic [O-1:0]   odat;
  logic [W-1:0]   oid;

  always #5 clk = ~clk;

  rtlrrpkt #(
    .N(N), .O(O), .I(N*O), .W(W), .MAXB(MAXB), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .eop(eop), .in(in),
    .gnt(gnt), .ovld(ovld), .ordy(ordy), .odat(odat),
    .oid(oid), .oeop(oeop), .err(err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Packet-level model: who owns the bus, beats so far in the packet.
  int         m_ptr, m_lock, m_beats, m_oid;
  logic       m_ovld, m_oeop, m_err;
  logic [7:0] m_odat;

  function automatic logic [N-1:0] mgnt();
    logic [N-1:0] r;
    int q;
    r = '0;
    if (rst || (m_ovld && !ordy)) return r;
    if (m_lock >= 0) begin
      if (req[m_lock]) r[m_lock] = 1'b1;
      return r;
    end
    for (int i = 0; i < N; i++) begin
      q = (m_ptr + i) % N;
      if (req[q]) begin
        r[q] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic mupd(input logic [N-1:0] g);
    int  q;
    bit  tr;
    if (rst) begin
      m_ptr = 0; m_lock = -1; m_beats = 0;
      m_ovld = 0; m_odat = 0; m_oid = 0; m_oeop = 0; m_err = 0;
    end else if (!m_ovld || ordy) begin
      if (g != 0) begin
        q = 0;
        for (int i = 0; i < N; i++) if (g[i]) q = i;
        m_beats = (m_lock < 0) ? 1 : m_beats + 1;
        tr      = !eop[q] && (m_beats == MAXB);
        m_ovld  = 1;
        m_odat  = in[q*O +: O];
        m_oid   = q;
        m_oeop  = eop[q] | tr;
        m_err   = tr;
        if (m_oeop) begin
          m_lock = -1;
          m_ptr  = (q + 1) % N;
        end else begin
          m_lock = q;
        end
      end else begin
        m_ovld = 0;
        m_err  = 0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] g;
    #1;
    g = mgnt();
    chk("gnt", gnt, g);
    @(posedge clk);
    mupd(g);
    #1;
    chk("ovld", ovld, m_ovld);
    chk("odat", odat, m_odat);
    chk("oid", oid, m_oid);
    chk("oeop", oeop, m_oeop);
    chk("err", err, m_err);
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] q;
    logic [N-1:0] e;
    logic         rd;
    logic [N-1:0] g;
    logic         v;
    logic [W-1:0] id;
    logic         eo;
  } row_t;

  row_t tbl[13];

  initial begin
    for (int i = 0; i < 7; i++)
      tbl[i] = '{1'b0, 6'h3f, 6'h3f, 1'b1,
                 6'b1 << (i % N), 1'b1, W'(i % N), 1'b1};
    tbl[7]  = '{1'b1, 6'h3f, 6'h3f, 1'b1, 6'h00, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{1'b0, 6'h09, 6'h08, 1'b1, 6'h01, 1'b1, 3'd0, 1'b0};
    tbl[9]  = '{1'b0, 6'h09, 6'h08, 1'b1, 6'h01, 1'b1, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 6'h09, 6'h08, 1'b1, 6'h01, 1'b1, 3'd0, 1'b0};
    tbl[11] = '{1'b0, 6'h09, 6'h09, 1'b1, 6'h01, 1'b1, 3'd0, 1'b1};
    tbl[12] = '{1'b0, 6'h09, 6'h09, 1'b1, 6'h08, 1'b1, 3'd3, 1'b1};

    m_ptr = 0; m_lock = -1; m_beats = 0;
    m_ovld = 0; m_odat = 0; m_oid = 0; m_oeop = 0; m_err = 0;
    in = {8'hf5, 8'he4, 8'hd3, 8'hc2, 8'hb1, 8'ha0};

    rst = 1; req = 0; eop = 0; ordy = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_ovld", ovld, 0);
    chk("idle_odat", odat, 0);
    chk("idle_oid", oid, 0);
    chk("idle_err", err, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; req = tbl[i].q; eop = tbl[i].e; ordy = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
      tick();
      chk($sformatf("tbl%0d_ovld", i), ovld, tbl[i].v);
      chk($sformatf("tbl%0d_oid", i), oid, tbl[i].id);
      chk($sformatf("tbl%0d_oeop", i), oeop, tbl[i].eo);
    end

    // Backpressure then same-cycle refill from ptr=4.
    req = 6'h3f; eop = 6'h3f; ordy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_gnt", gnt, 0);
      tick();
      chk("bp_oid", oid, 3);
      chk("bp_odat", odat, 8'hb1 + 8'h11 * 8'd2);
    end
    ordy = 1;
    #1;
    chk("bp_refill_gnt", gnt, 6'b010000);
    tick();
    chk("bp_refill_oid", oid, 4);

    // Forced release after MAXB beats of requester 2.
    rst = 1; tick(); rst = 0;
    req = 6'b000100; eop = 0;
    for (int b = 1; b <= MAXB; b++) begin
      in[2*O +: O] = 8'(b);
      tick();
      if (b == MAXB - 1) begin
        chk("fr15_oeop", oeop, 0);
        chk("fr15_err", err, 0);
      end
    end
    chk("fr16_oeop", oeop, 1);
    chk("fr16_err", err, 1);
    chk("fr16_odat", odat, MAXB);
    #1;
    chk("fr_regrant", gnt, 6'b000100);
    tick();
    chk("fr_err_clr", err, 0);
    req = 6'b000101;
    #1;
    chk("fr_locked", gnt, 6'b000100);

    // Reset while locked on requester 4 with a beat pending.
    rst = 1; tick(); rst = 0;
    req = 6'b010000; eop = 0; ordy = 0;
    tick(); tick();
    chk("rm_ovld_pre", ovld, 1);
    rst = 1;
    #1;
    chk("rm_gnt_rst", gnt, 0);
    tick();
    chk("rm_ovld", ovld, 0);
    rst = 0; req = 6'b100000; eop = 6'b100000;
    #1;
    chk("rm_gnt5", gnt, 6'b100000);
    tick();
    chk("rm_oid", oid, 5);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N; j++) begin
        req[j] = ($urandom_range(0, 2) != 0);
        eop[j] = ($urandom_range(0, 11) == 0);
      end
      in = {$urandom, $urandom};
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtlrrpkt.md
# rtlrrpkt

Round-robin packet arbiter placed directly upstream of the team's one-hot bus selector. It takes N requesters, each presenting an O-bit data lane, a request and an end-of-packet flag. It issues a one-hot grant that drives the selector enable and acknowledges the winning requester. It also registers the selected beat into a single valid/ready output stage, holding the grant on one requester until its packet ends or a maximum length forces release.

## Interface
- N, 6, number of requesters
- O, 8, data width per lane
- I, N*O, packed input width; lane k occupies in[k*O+O-1 : k*O]
- W, 3, requester id width; covers 0..N-1
- MAXB, 16, maximum beats per packet before forced release
- CW, 5, beat counter width; covers 0..MAXB
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- req  input  N  per-requester beat valid
- eop  input  N  per-requester end-of-packet flag, qualified by req
- in  input  I  packed requester data lanes
- gnt  output  N  one-hot grant; combinational; drives selector enable; gnt[k]=1 means lane k's beat is consumed this cycle
- ovld  output  1  output beat valid
- ordy  input  1  downstream ready
- odat  output  O  output beat data
- oid  output  W  id of requester that sourced odat
- oeop  output  1  output end-of-packet
- err  output  1  asserted with a beat truncated by the MAXB limit

## Operation
- Load enable: ld = ~ovld | ordy. Beats enter the output register only when ld=1.
- State: ptr (W bits, next priority index), lid (W bits, locked id), cnt (CW bits), FSM {IDLE, LOCK}.
- IDLE:
  - if ld and |req: winner w = first k with req[k]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Drive gnt = onehot(w) and load odat=lane w, oid=w, oeop=eop[w], ovld=1.
  - If eop[w]=1: stay IDLE; ptr <= (w==N-1)?0:w+1.
  - Else: go to LOCK; set lid=w and cnt=1.
- LOCK: only lid may be granted; gnt[lid] = req[lid] & ld, and all other gnt bits are 0.
  - Accepted beat loads lane lid; cnt <= cnt+1.
  - If eop[lid]=1: go to IDLE; ptr <= lid+1 mod N.
  - Else if cnt == MAXB-1, the accepted beat is the MAXB-th: go to IDLE; ptr <= lid+1 mod N. This beat is loaded with oeop=1 and err=1.
  - If req[lid]=0: no grant; stay LOCK. Other requesters wait, with no timeout on idle gaps.
- Output register: if ld=1 and no beat is granted, ovld <= 0. odat/oid/oeop hold their last values; err <= 0.
- While ovld=1 and ordy=0: gnt=0 and all output fields hold stable.
- err is a field of the output beat. It is valid only with ovld and cleared on the next load.
- MAXB=1 means every beat is a packet; in that case LOCK is never entered.

## Timing
- Reset (rst=1 at clock edge): ovld=0, odat=0, oid=0, oeop=0, err=0, ptr=0, lid=0, cnt=0, FSM=IDLE.
- gnt is forced 0 during the rst cycle; rst wins over any simultaneous request.
- Reset mid-packet discards the lock and any unaccepted output beat.
- gnt is combinational from req, eop, ovld, ordy and state, with no register.
- Requester data is sampled in the grant cycle; ovld rises on the next edge, giving 1-cycle latency.
- Full throughput: with ordy held 1, one beat per cycle. gnt and ordy may both be 1 in the same cycle (pass-through refill).
- ptr wraps from N-1 to 0. A single active requester is granted back-to-back packets with no bubble.

## Test plan
- Reset then idle: req=0 for 10 cycles -> ovld=0, gnt=0, odat=0, oid=0, err=0.
- Round robin: all req=1, all eop=1, ordy=1 -> gnt sequence 000001, 000010, ..., 100000, 000001. oid on consecutive beats is 0,1,2,3,4,5,0; one beat per cycle.
- Packet lock: req0 sends 4 beats (eop on 4th) while req3 is held high -> gnt stays 000001 for 4 beats, then 001000. Output oeop=1 only on beat 4 of id 0.
- Backpressure: ordy=0 for 3 cycles with ovld=1 -> gnt=0, odat/oid stable. On ordy=1, the next beat loads in the same cycle.
- Forced release: MAXB=16, req2 streams with eop=0 -> 16th beat has oeop=1, err=1. The next grant goes to the next active requester after 2, or back to 2 if it is the only one requesting.
- Reset mid-packet: rst during LOCK on id 4 with ovld=1 -> next cycle ovld=0, FSM IDLE, ptr=0; a subsequent req5-only request is granted immediately.
